// File: rtl/tp_pkg.sv
// Test-port reporter shared definitions.
// Bus widths, FSM states and the byte-order helper.
package tp_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] TEST_PORT_DEF = '0;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    GAP
  } state_e;

  // Readable (big-endian) word to bus (little-endian) byte order.
  function automatic logic [DATA_W-1:0] endian_swap32(
    input logic [DATA_W-1:0] v
  );
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/rpt_fifo.sv
// Report request FIFO.
// Count-based full/empty, pointers wrap modulo DEPTH.
module rpt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 62
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (PW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/test_port_reporter.sv
// Test-port bus master: queues report requests and
// issues each as one little-endian write with a gap.
module test_port_reporter
  import tp_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] TEST_PORT = TEST_PORT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rpt_valid,
  output logic              rpt_ready,
  input  logic [ADDR_W-1:0] rpt_addr,
  input  logic [DATA_W-1:0] rpt_data,
  input  logic              stall,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              wen,
  output logic              busy,
  output logic [7:0]        sent_count,
  output logic [15:0]       duration,
  output logic              done
);

  localparam int EW = ADDR_W + DATA_W;

  state_e          state;
  state_e          state_nx;
  logic            full;
  logic            empty;
  logic            pop;
  logic            wr_done;
  logic [EW-1:0]   head;

  assign rpt_ready = !full;
  assign busy      = (state != IDLE) || !empty;

  rpt_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rpt_valid),
    .pop   (pop),
    .din   ({rpt_addr, rpt_data}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state, pop and bus strobe.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    wen      = 1'b0;
    wr_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = WRITE;
        end
      end
      WRITE: begin
        wen = 1'b1;
        if (!stall) begin
          wr_done  = 1'b1;
          state_nx = GAP;
        end
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus address/data latched on pop, held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
      data <= '0;
    end else if (pop) begin
      addr <= head[EW-1 -: ADDR_W];
      data <= endian_swap32(head[DATA_W-1:0]);
    end
  end

  // Completed-write counter, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sent_count <= '0;
    end else if (wr_done && sent_count != 8'hFF) begin
      sent_count <= sent_count + 8'd1;
    end
  end

  // Duration runs until the first TEST_PORT write completes,
  // the completing cycle included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duration <= '0;
      done     <= 1'b0;
    end else if (!done) begin
      if (duration != 16'hFFFF) duration <= duration + 16'd1;
      if (wr_done && addr == TEST_PORT) done <= 1'b1;
    end
  end

endmodule
